multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Controls the multi-cycle multiply/divide unit in the execute stage.
- Detects MUL/DIV instructions in the D/X latch and captures their operands and instruction word.
- Issues a single start pulse to the multdiv unit and stalls the front of the pipeline until the result or an exception returns, or a watchdog expires.
- Presents one registered writeback record (data, destination register, exception flag) to the X/M stage.

Parameters:
- TIMEOUT, 40, max BUSY cycles waited for md_ready before a forced exception; legal range 2..63.
- STATUS_MUL, 4, value written to r30 (rstatus) on a multiply exception or timeout.
- STATUS_DIV, 5, value written to r30 (rstatus) on a divide exception or timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dx_ir  in  32  D/X instruction word; opcode = [31:27], ALU op = [6:2], rd = [26:22].
- dx_a  in  32  D/X operand A.
- dx_b  in  32  D/X operand B.
- md_result  in  32  multdiv unit result.
- md_ready  in  1  multdiv result valid, one-cycle pulse.
- md_exception  in  1  multdiv overflow/div-by-zero; qualified by md_ready.
- md_a  out  32  latched operand A to the multdiv unit.
- md_b  out  32  latched operand B to the multdiv unit.
- ctrl_mult  out  1  one-cycle multiply start pulse.
- ctrl_div  out  1  one-cycle divide start pulse.
- stall  out  1  freezes PC, F/D and D/X while high.
- wb_valid  out  1  writeback record valid, one cycle.
- wb_rd  out  5  writeback destination register.
- wb_data  out  32  writeback data.
- wb_exception  out  1  record is an rstatus exception write.

Behaviour:
- Decode: is_mul = (dx_ir[31:27]==0 && dx_ir[6:2]==6); is_div = (dx_ir[31:27]==0 && dx_ir[6:2]==7).
- States: IDLE, START, BUSY, DONE. The state register is updated only on rising clock edges or asynchronous reset.
- Reset (async, at any time, including mid-operation): state=IDLE. All outputs 0, latches 0, counter 0. Any in-flight md_ready arriving after reset is ignored.
- IDLE:
  - stall = is_mul|is_div (combinational, same cycle as decode).
  - On a clock edge with is_mul|is_div: latch dx_a→md_a, dx_b→md_b, dx_ir→ir_q and op type; clear the counter; go to START.
- START (exactly 1 cycle):
  - ctrl_mult or ctrl_div = 1 according to the latched op; stall = 1.
  - md_ready is ignored in this cycle.
  - Next state: BUSY.
- BUSY:
  - stall = 1; the counter increments every cycle.
  - On md_ready: capture md_result, md_exception and ir_q[26:22]; go to DONE.
  - If md_ready has not arrived and counter == TIMEOUT-1: force an exception record; go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE (exactly 1 cycle):
  - stall = 0, so the MUL/DIV leaves D/X this cycle.
  - Decode is suppressed in this cycle so the same instruction cannot re-trigger.
  - wb_valid = 1. Next state: IDLE.
- Writeback record:
  - Normal completion: wb_data = result, wb_rd = ir rd, wb_exception = 0. If rd == 0, wb_valid = 0 (r0 write suppressed).
  - Exception or timeout: wb_rd = 30, wb_data = STATUS_MUL or STATUS_DIV, wb_exception = 1, wb_valid = 1 regardless of rd.
- Outputs are registered except stall in IDLE.
- md_a and md_b hold their values from START until the next capture.
- Latency:
  - Decode edge → ctrl pulse in the next cycle.
  - md_ready edge → wb_valid in the next cycle.
  - Total stall cycles = 2 + BUSY cycles.
- Back-to-back MUL/DIV: the second instruction enters D/X after DONE, is decoded in IDLE, and restarts with no lost cycle beyond the IDLE decode.
- Non-MUL/DIV instructions in IDLE: no effect, stall = 0.

Test Plan:
- Reset defaults: assert reset mid-idle → all outputs 0, state IDLE; release → stall = 0 with dx_ir = 0.
- Multiply: MUL rd=3, A=7, B=6; md_ready with 42 three cycles after ctrl_mult → ctrl_mult pulses once; stall high from decode through BUSY; wb_valid=1, wb_rd=3, wb_data=42, wb_exception=0 for exactly one cycle; stall low in DONE.
- Divide by zero: DIV rd=5, B=0; md_ready with md_exception=1 → ctrl_div pulses once; wb_rd=30, wb_data=5, wb_exception=1.
- Timeout: MUL rd=4, md_ready never asserted, TIMEOUT=40 → DONE after 40 BUSY cycles; wb_rd=30, wb_data=4, wb_exception=1; stall drops.
- Back-to-back and r0 write: MUL rd=0 followed immediately by DIV rd=2 → first record has wb_valid=0; the second starts in the cycle after DONE with exactly one ctrl_div pulse; the first MUL never re-triggers.
- Reset mid-BUSY: assert reset two cycles after ctrl_mult, then drive md_ready → state IDLE; no wb_valid; stall=0.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Sequencer for the multi-cycle multiply/divide unit in the execute stage.
// Captures a MUL/DIV from D/X and issues one start pulse to the unit.
// Stalls the pipeline front until md_ready arrives or the watchdog expires.
// Then presents a single registered writeback record for one cycle.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT    = 40,
  parameter int unsigned STATUS_MUL = 4,
  parameter int unsigned STATUS_DIV = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int unsigned CNT_W = 6;
  localparam logic [4:0] OPC_RTYPE = 5'd0;
  localparam logic [4:0] ALU_MUL   = 5'd6;
  localparam logic [4:0] ALU_DIV   = 5'd7;
  localparam logic [4:0] RD_STATUS = 5'd30;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t           r_state;
  logic             r_is_div;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic             r_ctrl_mult;
  logic             r_ctrl_div;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_wb_exc;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_md;
  logic [31:0] w_status;
  logic        w_unused_ir;

  // Instruction decode of the D/X latch (only acted on in IDLE)
  assign w_is_mul = (dx_ir[31:27] == OPC_RTYPE) && (dx_ir[6:2] == ALU_MUL);
  assign w_is_div = (dx_ir[31:27] == OPC_RTYPE) && (dx_ir[6:2] == ALU_DIV);
  assign w_is_md  = w_is_mul | w_is_div;
  assign w_unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

  // rstatus code for the latched operation type
  assign w_status = r_is_div ? 32'(STATUS_DIV) : 32'(STATUS_MUL);

  // Stall is combinational only for the IDLE decode cycle; otherwise registered
  assign stall = ~reset & (r_stall | ((r_state == IDLE) & w_is_md));

  assign md_a         = r_md_a;
  assign md_b         = r_md_b;
  assign ctrl_mult    = r_ctrl_mult;
  assign ctrl_div     = r_ctrl_div;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_exception = r_wb_exc;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_is_div    <= 1'b0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_stall     <= 1'b0;
      r_md_a      <= '0;
      r_md_b      <= '0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_wb_exc    <= 1'b0;
    end else begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_is_md) begin
            r_md_a      <= dx_a;
            r_md_b      <= dx_b;
            r_rd        <= dx_ir[26:22];
            r_is_div    <= w_is_div;
            r_cnt       <= '0;
            r_ctrl_mult <= w_is_mul;
            r_ctrl_div  <= w_is_div;
            r_stall     <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          r_state <= BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (md_ready) begin
            r_stall <= 1'b0;
            r_state <= DONE;
            if (md_exception) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= RD_STATUS;
              r_wb_data  <= w_status;
              r_wb_exc   <= 1'b1;
            end else begin
              r_wb_valid <= (r_rd != 5'd0);
              r_wb_rd    <= r_rd;
              r_wb_data  <= md_result;
              r_wb_exc   <= 1'b0;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_stall    <= 1'b0;
            r_state    <= DONE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= RD_STATUS;
            r_wb_data  <= w_status;
            r_wb_exc   <= 1'b1;
          end
        end
        DONE: begin
          r_wb_rd   <= '0;
          r_wb_data <= '0;
          r_wb_exc  <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: a D/X pipeline model feeds a
// program, a behavioural multdiv unit answers after a per-op delay, and a
// scoreboard of expected writeback records is checked in each DONE cycle.
module tb_multdiv_sequencer;

  localparam int unsigned TIMEOUT    = 40;
  localparam int unsigned STATUS_MUL = 4;
  localparam int unsigned STATUS_DIV = 5;
  localparam logic [31:0] NOP        = 32'd0;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir, dx_a, dx_b, md_result;
  logic        md_ready, md_exception;
  logic [31:0] md_a, md_b, wb_data;
  logic        ctrl_mult, ctrl_div, stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;

  multdiv_sequencer #(
    .TIMEOUT(TIMEOUT), .STATUS_MUL(STATUS_MUL), .STATUS_DIV(STATUS_DIV)
  ) dut (
    .clock(clock), .reset(reset), .dx_ir(dx_ir), .dx_a(dx_a), .dx_b(dx_b),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .md_a(md_a), .md_b(md_b), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  // delay: cycles from the ctrl pulse to md_ready; 0 means never answer
  typedef struct {
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
  } op_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] a;
    logic [31:0] b;
    int          stalls;
    logic        is_div;
  } exp_t;

  op_t  prog[$];
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int md_cnt = 0;
  int cur_delay = 0;
  int stall_cnt = 0;
  int n_mult = 0;
  int n_div = 0;
  bit mon_en = 1'b0;
  bit md_seen = 1'b0;
  logic stall_s = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] cur_res = '0;
  logic        cur_exc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] alu);
    return {opc, rd, 15'd0, alu, 2'b00};
  endfunction

  // Put an instruction into D/X; MUL/DIV also arms the unit model and scoreboard
  task automatic load(input op_t op);
    logic [4:0] opc, alu, rd;
    logic       dv;
    exp_t       e;
    dx_ir = op.ir;
    dx_a  = op.a;
    dx_b  = op.b;
    opc = op.ir[31:27];
    alu = op.ir[6:2];
    rd  = op.ir[26:22];
    if (opc == 5'd0 && (alu == 5'd6 || alu == 5'd7)) begin
      dv        = (alu == 5'd7);
      cur_delay = op.delay;
      cur_exc   = dv && (op.b == 32'd0);
      cur_res   = dv ? ((op.b == 32'd0) ? 32'd0 : op.a / op.b) : op.a * op.b;
      e.a       = op.a;
      e.b       = op.b;
      e.is_div  = dv;
      e.stalls  = 2 + ((op.delay > 0) ? op.delay : int'(TIMEOUT));
      if (op.delay == 0 || cur_exc) begin
        e.valid = 1'b1;
        e.rd    = 5'd30;
        e.data  = dv ? 32'(STATUS_DIV) : 32'(STATUS_MUL);
        e.exc   = 1'b1;
      end else begin
        e.valid = (rd != 5'd0);
        e.rd    = rd;
        e.data  = cur_res;
        e.exc   = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic done_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'(e.valid));
      chk("wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("wb_data", wb_data, e.data);
      chk("wb_exception", 32'(wb_exception), 32'(e.exc));
      chk("md_a_hold", md_a, e.a);
      chk("md_b_hold", md_b, e.b);
      chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
      chk("ctrl_mult_pulses", 32'(n_mult), e.is_div ? 32'd0 : 32'd1);
      chk("ctrl_div_pulses", 32'(n_div), e.is_div ? 32'd1 : 32'd0);
    end
    stall_cnt = 0;
    n_mult    = 0;
    n_div     = 0;
  endtask

  // Observe outputs mid-cycle on the falling edge
  task automatic sample();
    @(negedge clock);
    if (mon_en) begin
      if (ctrl_mult) n_mult++;
      if (ctrl_div) n_div++;
      if ((ctrl_mult || ctrl_div) && cur_delay > 0) md_cnt = cur_delay;
      if (stall) stall_cnt++;
      if (prev_stall && !stall) done_check();
      else if (wb_valid) chk("wb_valid_outside_done", 32'(wb_valid), 32'd0);
    end
    prev_stall = stall;
    stall_s    = stall;
  endtask

  // Drive the unit model and advance D/X just after the rising edge
  task automatic drive();
    @(posedge clock);
    #1;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    md_result    = $urandom;
    if (md_cnt > 0) begin
      md_cnt--;
      if (md_cnt == 0) begin
        md_ready     = 1'b1;
        md_result    = cur_res;
        md_exception = cur_exc;
        md_seen      = 1'b1;
      end
    end
    if (!stall_s && !reset) begin
      if (prog.size() > 0) load(prog.pop_front());
      else begin
        dx_ir = NOP;
        dx_a  = '0;
        dx_b  = '0;
      end
    end
  endtask

  task automatic cycle();
    sample();
    drive();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_md_a"}, md_a, 32'd0);
    chk({pfx, "_md_b"}, md_b, 32'd0);
    chk({pfx, "_ctrl_mult"}, 32'(ctrl_mult), 32'd0);
    chk({pfx, "_ctrl_div"}, 32'(ctrl_div), 32'd0);
    chk({pfx, "_stall"}, 32'(stall), 32'd0);
    chk({pfx, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({pfx, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({pfx, "_wb_data"}, wb_data, 32'd0);
    chk({pfx, "_wb_exception"}, 32'(wb_exception), 32'd0);
  endtask

  function automatic op_t mkop(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b, input int d);
    op_t o;
    o.ir = ir;
    o.a = a;
    o.b = b;
    o.delay = d;
    return o;
  endfunction

  initial begin
    reset = 1'b1;
    dx_ir = NOP;
    dx_a = '0;
    dx_b = '0;
    md_result = '0;
    md_ready = 1'b0;
    md_exception = 1'b0;

    // Power-on reset, then a second reset asserted while idle
    repeat (2) cycle();
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (3) cycle();
    chk("idle_stall_nop", 32'(stall), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("idle_rst");
    cycle();
    reset = 1'b0;
    cycle();
    chk("post_rst_stall", 32'(stall), 32'd0);

    // Main program; consecutive entries enter D/X back-to-back
    prog.push_back(mkop(mk_ir(5'd0, 5'd3, 5'd6), 32'd7, 32'd6, 3));
    prog.push_back(mkop(NOP, 32'd0, 32'd0, 0));
    prog.push_back(mkop(mk_ir(5'd0, 5'd5, 5'd7), 32'd100, 32'd0, 2));
    prog.push_back(mkop(NOP, 32'd0, 32'd0, 0));
    prog.push_back(mkop(mk_ir(5'd0, 5'd4, 5'd6), 32'd11, 32'd13, 0));
    prog.push_back(mkop(mk_ir(5'd0, 5'd0, 5'd6), 32'd9, 32'd9, 2));
    prog.push_back(mkop(mk_ir(5'd0, 5'd2, 5'd7), 32'd100, 32'd7, 4));
    prog.push_back(mkop(mk_ir(5'd5, 5'd1, 5'd6), 32'd1, 32'd2, 0));
    prog.push_back(mkop(mk_ir(5'd0, 5'd8, 5'd8), 32'd1, 32'd2, 0));
    prog.push_back(mkop(mk_ir(5'd0, 5'd7, 5'd6), 32'hFFFF_FFFF, 32'd3, 1));
    prog.push_back(mkop(mk_ir(5'd0, 5'd9, 5'd7), 32'd1000, 32'd10, 40));
    prog.push_back(mkop(mk_ir(5'd0, 5'd31, 5'd7), 32'h8000_0000, 32'd2, 39));
    mon_en = 1'b1;
    for (int i = 0; i < 2000 && (prog.size() != 0 || sb.size() != 0); i++) cycle();
    chk("drain_pending", 32'(prog.size() + sb.size()), 32'd0);
    repeat (4) cycle();
    chk("no_retrigger_mult", 32'(n_mult), 32'd0);
    chk("no_retrigger_div", 32'(n_div), 32'd0);
    chk("final_idle_stall", 32'(stall), 32'd0);

    // Reset two cycles after the start pulse; a late md_ready must be ignored
    md_seen = 1'b0;
    prog.push_back(mkop(mk_ir(5'd0, 5'd6, 5'd6), 32'd3, 32'd9, 6));
    for (int i = 0; i < 50 && n_mult == 0; i++) cycle();
    chk("mid_busy_ctrl_seen", 32'(n_mult), 32'd1);
    cycle();
    reset = 1'b1;
    #1;
    check_reset_outputs("busy_rst");
    mon_en = 1'b0;
    sb.delete();
    dx_ir = NOP;
    dx_a = '0;
    dx_b = '0;
    cycle();
    reset = 1'b0;
    n_mult = 0;
    n_div = 0;
    stall_cnt = 0;
    prev_stall = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("busy_rst_stall", 32'(stall), 32'd0);
      chk("busy_rst_wb_valid", 32'(wb_valid), 32'd0);
    end
    chk("busy_rst_md_ready_driven", 32'(md_seen), 32'd1);
    chk("busy_rst_no_ctrl", 32'(n_mult + n_div), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
